// File: rtl/vga_glyph_fetch_scheduler_if.sv
// Bundles the slot-update port and the character ROM port of the glyph fetch scheduler.
// master = environment side (UART writer + ROM), slave = the scheduler.
// The update port is valid/ready; the ROM port has no backpressure and returns data one cycle after rom_rd.
interface vga_glyph_fetch_scheduler_if;
   logic        wr_valid;
   logic        wr_ready;
   logic [2:0]  wr_slot;
   logic [7:0]  wr_ascii;
   logic        rom_rd;
   logic [7:0]  rom_ascii;
   logic [4:0]  rom_row;
   logic [15:0] rom_data;

   modport master (
      output wr_valid, wr_slot, wr_ascii, rom_data,
      input  wr_ready, rom_rd, rom_ascii, rom_row
   );

   modport slave (
      input  wr_valid, wr_slot, wr_ascii, rom_data,
      output wr_ready, rom_rd, rom_ascii, rom_row
   );
endinterface

// File: rtl/vga_glyph_fetch_scheduler.sv
// Fetches one glyph row per text slot from a shared ROM during h-blank and serialises it as pixels.
// Latency: fetch takes NUM_CHARS+1 cycles from FETCH_H; pix_on/pix_in_text are 1 cycle behind h_count.
// Backpressure: wr_ready drops only in reset and in the frame-start commit cycle; the ROM never stalls.
module vga_glyph_fetch_scheduler #(
   parameter int NUM_CHARS = 4,
   parameter int H_START   = 448,
   parameter int V_START   = 259,
   parameter int GLYPH_H   = 32,
   parameter int FETCH_H   = 100
) (
   input  logic                       clk,
   input  logic                       clear_bar,
   input  logic [15:0]                h_count,
   input  logic [15:0]                v_count,
   vga_glyph_fetch_scheduler_if.slave bus,
   output logic                       pix_on,
   output logic                       pix_in_text,
   output logic                       overrun
);

   // Tables are sized for the largest legal slot count so every 3-bit index is in range;
   // entries at or above NUM_CHARS keep their reset value and are never displayed.
   localparam int          MAX_CHARS = 8;
   localparam logic [15:0] V_LO      = 16'(V_START);
   localparam logic [15:0] V_HI      = 16'(V_START + GLYPH_H);
   localparam logic [15:0] H_LO      = 16'(H_START);
   localparam logic [15:0] H_HI      = 16'(H_START + 16 * NUM_CHARS);
   localparam logic [15:0] FETCH_AT  = 16'(FETCH_H);
   localparam logic [2:0]  K_LAST    = 3'(NUM_CHARS - 1);
   localparam logic [3:0]  SLOT_LIM  = 4'(NUM_CHARS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state;
   logic [2:0]  k;
   logic [7:0]  shadow  [MAX_CHARS];
   logic [7:0]  active  [MAX_CHARS];
   logic [15:0] linebuf [MAX_CHARS];

   logic        commit;
   logic        wr_fire;
   logic        in_band;
   logic        in_box;
   logic [4:0]  row;
   logic [15:0] h_off;
   logic [2:0]  slot_sel;
   logic [3:0]  bit_sel;
   logic [15:0] sel_word;
   logic        pix_bit;

   // Frame-start commit cycle blocks updates so shadow is stable while it is copied.
   assign commit       = (h_count == 16'd0) && (v_count == 16'd0);
   assign bus.wr_ready = clear_bar && !commit;
   assign wr_fire      = bus.wr_valid && bus.wr_ready;

   // Line/box decode and pixel select for the current h_count.
   always_comb begin
      in_band  = (v_count >= V_LO) && (v_count < V_HI);
      in_box   = in_band && (h_count >= H_LO) && (h_count < H_HI);
      row      = 5'(v_count - V_LO);
      h_off    = h_count - H_LO;
      slot_sel = 3'(h_off >> 4);
      bit_sel  = 4'(h_off);
      sel_word = linebuf[slot_sel];
      pix_bit  = sel_word[4'd15 - bit_sel];
   end

   // Slot tables: UART writes land in shadow; shadow is copied to active once per frame.
   always_ff @(posedge clk) begin
      if (!clear_bar) begin
         for (int j = 0; j < MAX_CHARS; j++) begin
            shadow[j] <= 8'h30;
            active[j] <= 8'h30;
         end
      end else begin
         if (wr_fire && ({1'b0, bus.wr_slot} < SLOT_LIM)) begin
            shadow[bus.wr_slot] <= bus.wr_ascii;
         end
         if (commit) begin
            for (int j = 0; j < MAX_CHARS; j++) begin
               active[j] <= shadow[j];
            end
         end
      end
   end

   // Fetch FSM: registered ROM strobe per slot, capture of each word one cycle after its read.
   // In ISSUE with index k the ROM outputs currently carry issue k, so the word arriving now is k-1.
   always_ff @(posedge clk) begin
      if (!clear_bar) begin
         state         <= IDLE;
         k             <= 3'd0;
         bus.rom_rd    <= 1'b0;
         bus.rom_ascii <= 8'h00;
         bus.rom_row   <= 5'd0;
         for (int j = 0; j < MAX_CHARS; j++) begin
            linebuf[j] <= 16'h0000;
         end
      end else begin
         case (state)
            IDLE: begin
               if (h_count == FETCH_AT) begin
                  if (in_band) begin
                     state         <= ISSUE;
                     k             <= 3'd0;
                     bus.rom_rd    <= 1'b1;
                     bus.rom_ascii <= active[0];
                     bus.rom_row   <= row;
                  end else begin
                     for (int j = 0; j < MAX_CHARS; j++) begin
                        linebuf[j] <= 16'h0000;
                     end
                  end
               end
            end
            ISSUE: begin
               if (k != 3'd0) begin
                  linebuf[k - 3'd1] <= bus.rom_data;
               end
               if (k == K_LAST) begin
                  state      <= DRAIN;
                  bus.rom_rd <= 1'b0;
               end else begin
                  k             <= k + 3'd1;
                  bus.rom_ascii <= active[k + 3'd1];
               end
            end
            DRAIN: begin
               linebuf[K_LAST] <= bus.rom_data;
               state           <= IDLE;
            end
            default: begin
               state      <= IDLE;
               bus.rom_rd <= 1'b0;
            end
         endcase
      end
   end

   // Registered pixel outputs and the sticky late-fetch flag.
   always_ff @(posedge clk) begin
      if (!clear_bar) begin
         pix_on      <= 1'b0;
         pix_in_text <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         pix_in_text <= in_box;
         pix_on      <= in_box && pix_bit;
         if ((h_count == H_LO) && (state != IDLE)) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_glyph_fetch_scheduler.sv
// Directed bench for the glyph fetch scheduler: vector table plus hand sequences.
// A second instance with a late FETCH_H exercises the overrun flag.
// The ROM model returns a scripted word per issue slot, one cycle after rom_rd.
module tb_vga_glyph_fetch_scheduler;
   logic        clk = 1'b0;
   logic        clear_bar;
   logic [15:0] h_count;
   logic [15:0] v_count;
   logic        pix_on, pix_in_text, overrun;
   logic        pix_on2, pix_in_text2, overrun2;

   int checks = 0;
   int errors = 0;

   logic [15:0] script [4];

   vga_glyph_fetch_scheduler_if bus ();
   vga_glyph_fetch_scheduler_if bus2 ();

   always #5 clk = ~clk;

   vga_glyph_fetch_scheduler #(
      .NUM_CHARS(4), .H_START(448), .V_START(259), .GLYPH_H(32), .FETCH_H(100)
   ) dut (
      .clk(clk), .clear_bar(clear_bar), .h_count(h_count), .v_count(v_count),
      .bus(bus), .pix_on(pix_on), .pix_in_text(pix_in_text), .overrun(overrun)
   );

   vga_glyph_fetch_scheduler #(
      .NUM_CHARS(4), .H_START(448), .V_START(259), .GLYPH_H(32), .FETCH_H(446)
   ) dut2 (
      .clk(clk), .clear_bar(clear_bar), .h_count(h_count), .v_count(v_count),
      .bus(bus2), .pix_on(pix_on2), .pix_in_text(pix_in_text2), .overrun(overrun2)
   );

   // Issue k of a fetch starting at h=100 is read while h_count = 101+k.
   function automatic logic [15:0] rom_word(input logic [15:0] h);
      int i;
      i = int'(h) - 101;
      if (i >= 0 && i < 4) return script[i];
      return 16'hDEAD;
   endfunction

   always @(posedge clk) begin
      if (bus.rom_rd) bus.rom_data <= rom_word(h_count);
   end

   typedef struct {
      int         h;
      int         v;
      logic       rd;
      logic [7:0] ascii;
      logic [4:0] row;
      logic       pix;
      logic       txt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int h, input int v, input logic rd, input logic [7:0] a,
                      input logic [4:0] r, input logic p, input logic t);
      vec_t e;
      e.h = h; e.v = v; e.rd = rd; e.ascii = a; e.row = r; e.pix = p; e.txt = t;
      tbl.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int h, input int v);
      h_count = 16'(h);
      v_count = 16'(v);
      @(posedge clk);
      #1;
   endtask

   task automatic check_linebuf(input string tag, input logic [63:0] exp);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s linebuf[%0d]", tag, i), 32'(dut.linebuf[i]), 32'(exp[16*(3-i) +: 16]));
   endtask

   // Runs h=99..106 on line v and checks the four issues and their ASCII codes.
   task automatic fetch_check(input string tag, input int v, input logic [31:0] exps);
      for (int h = 99; h <= 106; h++) begin
         tick(h, v);
         if (h >= 100 && h <= 103) begin
            check($sformatf("%s rd h=%0d", tag, h), 32'(bus.rom_rd), 32'd1);
            check($sformatf("%s ascii h=%0d", tag, h), 32'(bus.rom_ascii), 32'(exps[8*(3-(h-100)) +: 8]));
            check($sformatf("%s row h=%0d", tag, h), 32'(bus.rom_row), 32'(v - 259));
         end else begin
            check($sformatf("%s rd h=%0d", tag, h), 32'(bus.rom_rd), 32'd0);
         end
      end
   endtask

   task automatic do_write(input logic [2:0] slot, input logic [7:0] a, input int h, input int v);
      bus.wr_valid = 1'b1;
      bus.wr_slot  = slot;
      bus.wr_ascii = a;
      h_count = 16'(h);
      v_count = 16'(v);
      #1;
      check($sformatf("wr_ready write slot %0d", slot), 32'(bus.wr_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b0;
   endtask

   task automatic commit_frame(input string tag);
      h_count = 16'd0;
      v_count = 16'd0;
      #1;
      check($sformatf("%s wr_ready commit", tag), 32'(bus.wr_ready), 32'd0);
      tick(0, 0);
      bus.wr_valid = 1'b0;
   endtask

   initial begin
      clear_bar     = 1'b0;
      h_count       = 16'd10;
      v_count       = 16'd10;
      bus.wr_valid  = 1'b0;
      bus.wr_slot   = 3'd0;
      bus.wr_ascii  = 8'h00;
      bus.rom_data  = 16'h0000;
      bus2.wr_valid = 1'b0;
      bus2.wr_slot  = 3'd0;
      bus2.wr_ascii = 8'h00;
      bus2.rom_data = 16'h0000;
      script[0] = 16'hA001; script[1] = 16'h0001; script[2] = 16'h0002; script[3] = 16'h0003;

      // Reset held for 3 cycles.
      for (int i = 0; i < 3; i++) tick(10, 10);
      check("rst rom_rd", 32'(bus.rom_rd), 32'd0);
      check("rst rom_ascii", 32'(bus.rom_ascii), 32'd0);
      check("rst rom_row", 32'(bus.rom_row), 32'd0);
      check("rst pix_on", 32'(pix_on), 32'd0);
      check("rst pix_in_text", 32'(pix_in_text), 32'd0);
      check("rst overrun", 32'(overrun), 32'd0);
      check("rst wr_ready", 32'(bus.wr_ready), 32'd0);
      check_linebuf("rst", 64'h0);
      clear_bar = 1'b1;
      #1;
      check("wr_ready after reset", 32'(bus.wr_ready), 32'd1);

      // Fetch on v=261 (row 2), then pixels of A001/0001/0002/0003.
      add(99,  261, 0, 8'h00, 5'd0, 0, 0);
      add(100, 261, 1, 8'h30, 5'd2, 0, 0);
      add(101, 261, 1, 8'h30, 5'd2, 0, 0);
      add(102, 261, 1, 8'h30, 5'd2, 0, 0);
      add(103, 261, 1, 8'h30, 5'd2, 0, 0);
      add(104, 261, 0, 8'h00, 5'd0, 0, 0);
      add(105, 261, 0, 8'h00, 5'd0, 0, 0);
      add(447, 261, 0, 8'h00, 5'd0, 0, 0);
      add(448, 261, 0, 8'h00, 5'd0, 1, 1);
      add(449, 261, 0, 8'h00, 5'd0, 0, 1);
      add(450, 261, 0, 8'h00, 5'd0, 1, 1);
      add(451, 261, 0, 8'h00, 5'd0, 0, 1);
      add(463, 261, 0, 8'h00, 5'd0, 1, 1);
      add(464, 261, 0, 8'h00, 5'd0, 0, 1);
      add(478, 261, 0, 8'h00, 5'd0, 0, 1);
      add(479, 261, 0, 8'h00, 5'd0, 1, 1);
      add(494, 261, 0, 8'h00, 5'd0, 1, 1);
      add(495, 261, 0, 8'h00, 5'd0, 0, 1);
      add(509, 261, 0, 8'h00, 5'd0, 0, 1);
      add(510, 261, 0, 8'h00, 5'd0, 1, 1);
      add(511, 261, 0, 8'h00, 5'd0, 1, 1);
      add(512, 261, 0, 8'h00, 5'd0, 0, 0);
      add(448, 300, 0, 8'h00, 5'd0, 0, 0);
      add(450, 258, 0, 8'h00, 5'd0, 0, 0);
      add(450, 290, 0, 8'h00, 5'd0, 1, 1);
      add(450, 291, 0, 8'h00, 5'd0, 0, 0);
      foreach (tbl[i]) begin
         tick(tbl[i].h, tbl[i].v);
         check($sformatf("vec%0d rom_rd", i), 32'(bus.rom_rd), 32'(tbl[i].rd));
         if (tbl[i].rd) begin
            check($sformatf("vec%0d rom_ascii", i), 32'(bus.rom_ascii), 32'(tbl[i].ascii));
            check($sformatf("vec%0d rom_row", i), 32'(bus.rom_row), 32'(tbl[i].row));
         end
         check($sformatf("vec%0d pix_on", i), 32'(pix_on), 32'(tbl[i].pix));
         check($sformatf("vec%0d pix_in_text", i), 32'(pix_in_text), 32'(tbl[i].txt));
      end
      check_linebuf("fetch261", {16'hA001, 16'h0001, 16'h0002, 16'h0003});

      // Serialisation of 8001 on glyph row 0.
      script[0] = 16'h8001; script[1] = 16'h0000; script[2] = 16'h0000; script[3] = 16'h0000;
      fetch_check("fetch259", 259, {8'h30, 8'h30, 8'h30, 8'h30});
      for (int h = 447; h <= 513; h++) begin
         tick(h, 259);
         check($sformatf("sweep pix_on h=%0d", h), 32'(pix_on), 32'(h == 448 || h == 463));
         check($sformatf("sweep pix_in_text h=%0d", h), 32'(pix_in_text), 32'(h >= 448 && h < 512));
      end

      // Out-of-band line clears the line buffer at FETCH_H without touching the ROM.
      tick(100, 300);
      check("oob rom_rd", 32'(bus.rom_rd), 32'd0);
      tick(101, 300);
      check_linebuf("oob", 64'h0);
      tick(448, 259);
      check("oob pix_on", 32'(pix_on), 32'd0);
      check("oob pix_in_text", 32'(pix_in_text), 32'd1);

      // Update lands in shadow only; display changes after the next commit.
      do_write(3'd1, 8'h37, 200, 262);
      fetch_check("pre-commit", 263, {8'h30, 8'h30, 8'h30, 8'h30});
      h_count = 16'd0; v_count = 16'd1;
      #1;
      check("wr_ready h0 v1", 32'(bus.wr_ready), 32'd1);
      h_count = 16'd1; v_count = 16'd0;
      #1;
      check("wr_ready h1 v0", 32'(bus.wr_ready), 32'd1);
      commit_frame("c1");
      fetch_check("post-commit", 259, {8'h30, 8'h37, 8'h30, 8'h30});
      check_linebuf("post-commit", {16'h8001, 16'h0000, 16'h0000, 16'h0000});

      // Out-of-range slot is accepted and dropped; a write offered in the commit cycle is not taken.
      do_write(3'd5, 8'h41, 200, 300);
      bus.wr_valid = 1'b1;
      bus.wr_slot  = 3'd2;
      bus.wr_ascii = 8'h55;
      commit_frame("c2");
      commit_frame("c3");
      fetch_check("slot5", 260, {8'h30, 8'h37, 8'h30, 8'h30});

      // Reset in the middle of a fetch.
      script[0] = 16'h1111; script[1] = 16'h2222; script[2] = 16'h3333; script[3] = 16'h4444;
      tick(99, 261);
      tick(100, 261);
      tick(101, 261);
      clear_bar = 1'b0;
      tick(102, 261);
      clear_bar = 1'b1;
      check("midrst rom_rd", 32'(bus.rom_rd), 32'd0);
      check("midrst state", 32'(dut.state), 32'd0);
      check_linebuf("midrst", 64'h0);
      tick(103, 261);
      check("midrst rom_rd h=103", 32'(bus.rom_rd), 32'd0);
      fetch_check("after midrst", 262, {8'h30, 8'h30, 8'h30, 8'h30});
      check_linebuf("after midrst", {16'h1111, 16'h2222, 16'h3333, 16'h4444});

      // Late fetch on the second instance sets the sticky overrun flag.
      check("overrun2 start", 32'(overrun2), 32'd0);
      tick(445, 259);
      tick(446, 259);
      tick(447, 259);
      check("overrun2 h=447", 32'(overrun2), 32'd0);
      tick(448, 259);
      check("overrun2 h=448", 32'(overrun2), 32'd1);
      for (int h = 449; h <= 460; h++) tick(h, 259);
      tick(0, 0);
      tick(100, 300);
      tick(448, 270);
      check("overrun2 sticky", 32'(overrun2), 32'd1);
      check("overrun main", 32'(overrun), 32'd0);
      clear_bar = 1'b0;
      tick(10, 10);
      clear_bar = 1'b1;
      check("overrun2 cleared", 32'(overrun2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
